// File: rtl/axil_master_gfi.sv
// AXI4-Lite master: turns single local requests into AXI4-Lite writes/reads, one outstanding at a time.
// Optional watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN (TIMEOUT_CYC cycles, reports 2'b10).
module axil_master_gfi #(
  parameter int ADRES_BIT   = 32,
  parameter int VERI_BIT    = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  istek_gecerli,
  output logic                  istek_hazir,
  input  logic                  istek_yaz,
  input  logic [ADRES_BIT-1:0]  istek_adres,
  input  logic [VERI_BIT-1:0]   istek_veri,
  input  logic [VERI_BIT/8-1:0] istek_strb,
  output logic                  yanit_gecerli,
  input  logic                  yanit_hazir,
  output logic [VERI_BIT-1:0]   yanit_veri,
  output logic [1:0]            yanit_hata,
  output logic [ADRES_BIT-1:0]  AWADDR,
  output logic                  AWVALID,
  output logic [2:0]            AWPROT,
  input  logic                  AWREADY,
  output logic [VERI_BIT-1:0]   WDATA,
  output logic [VERI_BIT/8-1:0] WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic [1:0]            BRESP,
  output logic                  BREADY,
  output logic [ADRES_BIT-1:0]  ARADDR,
  output logic                  ARVALID,
  output logic [2:0]            ARPROT,
  input  logic                  ARREADY,
  input  logic [VERI_BIT-1:0]   RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    BOSTA, YAZ_ADRES, YAZ_YANIT, OKU_ADRES, OKU_VERI, YANIT
  } durum_t;

  durum_t                durum, durum_n;
  logic [ADRES_BIT-1:0]  adres_q, adres_n;
  logic [VERI_BIT-1:0]   veri_q, veri_n;
  logic [VERI_BIT/8-1:0] strb_q, strb_n;
  logic                  hazir_n, awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  logic                  yg_n;
  logic [VERI_BIT-1:0]   yv_n;
  logic [1:0]            yh_n;
  logic                  zaman_asimi;

  // Both address channels share one latched request address.
  assign AWADDR = adres_q;
  assign ARADDR = adres_q;
  assign WDATA  = veri_q;
  assign WSTRB  = strb_q;
  assign AWPROT = '0;
  assign ARPROT = '0;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int SAYAC_BIT = $clog2(TIMEOUT_CYC + 1);
  logic [SAYAC_BIT-1:0] sayac;
  logic                 mesgul;

  assign mesgul      = (durum != BOSTA) && (durum != YANIT);
  assign zaman_asimi = mesgul && (sayac == SAYAC_BIT'(TIMEOUT_CYC - 1));

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)    sayac <= '0;
    else if (!mesgul) sayac <= '0;
    else if (!zaman_asimi) sayac <= sayac + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign zaman_asimi    = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      durum         <= BOSTA;
      adres_q       <= '0;
      veri_q        <= '0;
      strb_q        <= '0;
      istek_hazir   <= 1'b1;
      AWVALID       <= 1'b0;
      WVALID        <= 1'b0;
      BREADY        <= 1'b0;
      ARVALID       <= 1'b0;
      RREADY        <= 1'b0;
      yanit_gecerli <= 1'b0;
      yanit_veri    <= '0;
      yanit_hata    <= '0;
    end else begin
      durum         <= durum_n;
      adres_q       <= adres_n;
      veri_q        <= veri_n;
      strb_q        <= strb_n;
      istek_hazir   <= hazir_n;
      AWVALID       <= awvalid_n;
      WVALID        <= wvalid_n;
      BREADY        <= bready_n;
      ARVALID       <= arvalid_n;
      RREADY        <= rready_n;
      yanit_gecerli <= yg_n;
      yanit_veri    <= yv_n;
      yanit_hata    <= yh_n;
    end
  end

  always_comb begin
    durum_n   = durum;
    adres_n   = adres_q;
    veri_n    = veri_q;
    strb_n    = strb_q;
    hazir_n   = istek_hazir;
    awvalid_n = AWVALID;
    wvalid_n  = WVALID;
    bready_n  = BREADY;
    arvalid_n = ARVALID;
    rready_n  = RREADY;
    yg_n      = yanit_gecerli;
    yv_n      = yanit_veri;
    yh_n      = yanit_hata;

    unique case (durum)
      BOSTA: begin
        if (istek_gecerli) begin
          adres_n = istek_adres;
          veri_n  = istek_veri;
          strb_n  = istek_strb;
          hazir_n = 1'b0;
          if (istek_yaz) begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            durum_n   = YAZ_ADRES;
          end else begin
            arvalid_n = 1'b1;
            durum_n   = OKU_ADRES;
          end
        end
      end
      YAZ_ADRES: begin
        // Each VALID clears only on its own handshake; move on once both are gone.
        awvalid_n = AWVALID & ~AWREADY;
        wvalid_n  = WVALID & ~WREADY;
        if (!awvalid_n && !wvalid_n) begin
          bready_n = 1'b1;
          durum_n  = YAZ_YANIT;
        end
      end
      YAZ_YANIT: begin
        if (BVALID) begin
          yh_n     = BRESP;
          yv_n     = '0;
          bready_n = 1'b0;
          yg_n     = 1'b1;
          durum_n  = YANIT;
        end
      end
      OKU_ADRES: begin
        if (ARREADY) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          durum_n   = OKU_VERI;
        end
      end
      OKU_VERI: begin
        if (RVALID) begin
          yv_n     = RDATA;
          yh_n     = RRESP;
          rready_n = 1'b0;
          yg_n     = 1'b1;
          durum_n  = YANIT;
        end
      end
      YANIT: begin
        if (yanit_hazir) begin
          yg_n    = 1'b0;
          hazir_n = 1'b1;
          durum_n = BOSTA;
        end
      end
      default: durum_n = BOSTA;
    endcase

    // Expiry applies only when the state did not progress this cycle, so a handshake wins.
    if (zaman_asimi && (durum_n == durum)) begin
      awvalid_n = 1'b0;
      wvalid_n  = 1'b0;
      bready_n  = 1'b0;
      arvalid_n = 1'b0;
      rready_n  = 1'b0;
      yg_n      = 1'b1;
      yv_n      = '0;
      yh_n      = 2'b10;
      durum_n   = YANIT;
    end
  end

endmodule

// File: tb/tb_axil_master_gfi.sv
// Scoreboard bench for axil_master_gfi with a configurable-latency AXI4-Lite slave model.
module tb_axil_master_gfi;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        istek_gecerli, istek_hazir, istek_yaz;
  logic [31:0] istek_adres, istek_veri;
  logic [3:0]  istek_strb;
  logic        yanit_gecerli, yanit_hazir;
  logic [31:0] yanit_veri;
  logic [1:0]  yanit_hata;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;

  axil_master_gfi #(.ADRES_BIT(32), .VERI_BIT(32), .TIMEOUT_CYC(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .istek_gecerli(istek_gecerli), .istek_hazir(istek_hazir), .istek_yaz(istek_yaz),
    .istek_adres(istek_adres), .istek_veri(istek_veri), .istek_strb(istek_strb),
    .yanit_gecerli(yanit_gecerli), .yanit_hazir(yanit_hazir),
    .yanit_veri(yanit_veri), .yanit_hata(yanit_hata),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWPROT(AWPROT), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARPROT(ARPROT), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] veri;
    logic [1:0]  hata;
  } beklenen_t;

  beklenen_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Slave model configuration
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  bit          ar_never = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = 0;
  end

  // Slave drives on the falling edge; each READY/VALID appears after the configured wait.
  always @(negedge ACLK) begin
    if (AWVALID) begin AWREADY = (aw_cnt == aw_wait); aw_cnt++; end
    else begin AWREADY = 0; aw_cnt = 0; end
    if (WVALID) begin WREADY = (w_cnt == w_wait); w_cnt++; end
    else begin WREADY = 0; w_cnt = 0; end
    if (ARVALID) begin ARREADY = !ar_never && (ar_cnt == ar_wait); ar_cnt++; end
    else begin ARREADY = 0; ar_cnt = 0; end
    if (BREADY) begin BVALID = (b_cnt == b_wait); BRESP = bresp_cfg; b_cnt++; end
    else begin BVALID = 0; b_cnt = 0; end
    if (RREADY) begin RVALID = (r_cnt == r_wait); RDATA = rdata_cfg; RRESP = rresp_cfg; r_cnt++; end
    else begin RVALID = 0; r_cnt = 0; end
  end

  // Response monitor: a handshake will occur at the next rising edge.
  always @(negedge ACLK) begin
    if (ARESETN && yanit_gecerli && yanit_hazir) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_resp", 1, 0);
      end else begin
        beklenen_t e;
        e = exp_q.pop_front();
        check_val("yanit_veri", yanit_veri, e.veri);
        check_val("yanit_hata", yanit_hata, e.hata);
      end
    end
  end

  // Drives a request and returns on the rising edge where it is accepted.
  task automatic send(input logic yaz, input logic [31:0] adres, input logic [31:0] veri,
                      input logic [3:0] strb, input logic [31:0] e_veri, input logic [1:0] e_hata);
    bit ok;
    beklenen_t e;
    istek_gecerli = 1; istek_yaz = yaz; istek_adres = adres;
    istek_veri = veri; istek_strb = strb;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (istek_hazir) begin ok = 1; break; end
    end
    if (!ok) check_val("req_accept", 0, 1);
    else begin
      e.veri = e_veri; e.hata = e_hata;
      exp_q.push_back(e);
    end
    @(posedge ACLK);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge ACLK);
    end
    check_val("resp_drained", exp_q.size(), 0);
    @(posedge ACLK); @(posedge ACLK); #1;
  endtask

  initial begin
    ARESETN = 0; istek_gecerli = 0; istek_yaz = 0; istek_adres = '0;
    istek_veri = '0; istek_strb = '0; yanit_hazir = 1;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1;
    @(negedge ACLK);
    check_val("rst_istek_hazir", istek_hazir, 1);
    check_val("rst_valids", {AWVALID, WVALID, ARVALID}, 0);
    check_val("rst_readys", {BREADY, RREADY}, 0);
    check_val("rst_yanit", {yanit_gecerli, yanit_veri, yanit_hata}, 0);
    check_val("rst_regs", {AWADDR, WDATA}, 0);
    check_val("rst_prot", {AWPROT, ARPROT}, 0);
    @(posedge ACLK); #1;

    // Zero-wait write with exact cycle timing
    send(1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00);
    #1 istek_gecerli = 0;
    @(negedge ACLK);
    check_val("w0_c1_valids", {AWVALID, WVALID}, 2'b11);
    check_val("w0_awaddr", AWADDR, 32'h10);
    check_val("w0_wdata", WDATA, 32'hDEADBEEF);
    check_val("w0_wstrb", WSTRB, 4'hF);
    check_val("w0_c1_hazir", istek_hazir, 0);
    @(negedge ACLK);
    check_val("w0_c2_valids", {AWVALID, WVALID}, 2'b00);
    check_val("w0_c2_bready", BREADY, 1);
    @(negedge ACLK);
    check_val("w0_c3_gecerli", yanit_gecerli, 1);
    check_val("w0_c3_bready", BREADY, 0);
    @(negedge ACLK);
    check_val("w0_c4_hazir", istek_hazir, 1);
    check_val("w0_c4_gecerli", yanit_gecerli, 0);
    wait_resp();

    // Split write: AWREADY two cycles ahead of WREADY
    aw_wait = 1; w_wait = 3;
    send(1, 32'h14, 32'h0BADF00D, 4'h5, 32'h0, 2'b00);
    #1 istek_gecerli = 0;
    @(negedge ACLK);
    check_val("sw_c1", {AWVALID, WVALID, BREADY}, 3'b110);
    @(negedge ACLK);
    check_val("sw_c2", {AWVALID, WVALID, BREADY}, 3'b110);
    @(negedge ACLK);
    check_val("sw_c3_aw_dropped", {AWVALID, WVALID, BREADY}, 3'b010);
    check_val("sw_wstrb_stable", WSTRB, 4'h5);
    @(negedge ACLK);
    check_val("sw_c4", {AWVALID, WVALID, BREADY}, 3'b010);
    @(negedge ACLK);
    check_val("sw_c5_bready", {AWVALID, WVALID, BREADY}, 3'b001);
    wait_resp();
    aw_wait = 0; w_wait = 0;

    // Read with three slave wait cycles on R
    rdata_cfg = 32'h12345678; rresp_cfg = 2'b00; r_wait = 3;
    send(0, 32'h20, 32'h0, 4'h0, 32'h12345678, 2'b00);
    #1 istek_gecerli = 0;
    @(negedge ACLK);
    check_val("rd_arvalid", ARVALID, 1);
    check_val("rd_araddr", ARADDR, 32'h20);
    check_val("rd_no_aw", {AWVALID, WVALID}, 0);
    wait_resp();
    r_wait = 0;

    // Backpressure on response, next request (error write) held pending
    yanit_hazir = 0; rdata_cfg = 32'hCAFEF00D; rresp_cfg = 2'b01; bresp_cfg = 2'b10;
    send(0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 2'b01);
    #1 istek_yaz = 1; istek_adres = 32'h40; istek_veri = 32'h55AA55AA; istek_strb = 4'hF;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (yanit_gecerli) break;
    end
    check_val("bp_gecerli_rise", yanit_gecerli, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check_val("bp_stable", {yanit_gecerli, yanit_veri, yanit_hata}, {1'b1, 32'hCAFEF00D, 2'b01});
      check_val("bp_hazir_low", istek_hazir, 0);
    end
    @(posedge ACLK);
    #1 yanit_hazir = 1;
    send(1, 32'h40, 32'h55AA55AA, 4'hF, 32'h0, 2'b10);
    #1 istek_gecerli = 0;
    wait_resp();
    bresp_cfg = 2'b00;

    // Reset pulse in the middle of a read
    ar_wait = 3;
    send(0, 32'h50, 32'h0, 4'h0, 32'h0, 2'b00);
    #1 istek_gecerli = 0;
    @(negedge ACLK);
    check_val("mr_arvalid", ARVALID, 1);
    #2 ARESETN = 0;
    #1;
    check_val("mr_valids", {AWVALID, WVALID, ARVALID}, 0);
    check_val("mr_readys", {BREADY, RREADY}, 0);
    check_val("mr_yanit", yanit_gecerli, 0);
    exp_q.delete();
    @(posedge ACLK);
    #1 ARESETN = 1;
    @(negedge ACLK);
    check_val("mr_hazir_after", istek_hazir, 1);
    check_val("mr_arvalid_after", ARVALID, 0);
    ar_wait = 0;
    @(posedge ACLK); #1;

    // Post-reset write with a partial strobe
    send(1, 32'h60, 32'h01020304, 4'h3, 32'h0, 2'b00);
    #1 istek_gecerli = 0;
    @(negedge ACLK);
    check_val("pr_wstrb", WSTRB, 4'h3);
    check_val("pr_awaddr", AWADDR, 32'h60);
    wait_resp();

`ifdef AXIL_MASTER_TIMEOUT_EN
    // ARREADY never asserted: watchdog must complete with code 10 and zero data
    ar_never = 1; rdata_cfg = 32'hFFFFFFFF;
    send(0, 32'h70, 32'h0, 4'h0, 32'h0, 2'b10);
    #1 istek_gecerli = 0;
    wait_resp();
    check_val("to_arvalid", ARVALID, 0);
    check_val("to_hazir", istek_hazir, 1);
    ar_never = 0;
`endif

    check_val("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
